regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Writeback-side driver for the 32-entry register file: collects results from two producers (ALU, MEM), buffers each in a small FIFO, and issues at most one regfile write per cycle on the regfile's write port (w_en/rd_addr/w_data). Sits between the execute/memory stages and the regfile. It also exports a pending-write mask that the issue logic uses for RAW hazard stalls.

## Interface
- WIDTH, 32, data width; matches regfile WIDTH
- DEPTH, 2, entries per source FIFO; power of two, ≥2
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- s0_valid  input  1  ALU result valid
- s0_ready  output  1  ALU FIFO can accept
- s0_rd_addr  input  5  ALU destination register
- s0_data  input  WIDTH  ALU result
- s1_valid  input  1  MEM result valid
- s1_ready  output  1  MEM FIFO can accept
- s1_rd_addr  input  5  MEM destination register
- s1_data  input  WIDTH  MEM result
- w_en  output  1  regfile write enable (registered)
- rd_addr  output  5  regfile write address (registered)
- w_data  output  WIDTH  regfile write data (registered)
- busy  output  32  bit i set while a write to register i is queued or in the output stage; bit 0 always 0

## Operation
- Accept on sN_valid && sN_ready at rising edge; entry {rd_addr, data} pushed into FIFO N.
- sN_ready = !full(FIFO N); depends on registered state only, never on sN_valid. No push when full, even if a pop occurs the same cycle.
- Each cycle, at most one FIFO head is popped:
  - Only one non-empty: pop it.
  - Both non-empty: round-robin. Pop the source not granted last; last_grant updates on every pop.
  - After reset, last_grant = 1, so s0 wins the first tie.
- A popped entry with rd_addr ≠ 0 loads the output stage: w_en=1, rd_addr, w_data.
- A popped entry with rd_addr == 0 is discarded: w_en=0 next cycle. It still counts as a grant for rotation.
- No pop: w_en=0; rd_addr and w_data hold their previous values.
- Within one FIFO, entries leave in arrival order. Across sources, order follows arbitration only.
- busy is the OR of one-hot(rd_addr) over:
  - all valid entries in both FIFOs
  - the output stage when w_en=1
  - bit 0 is masked to 0
- busy is combinational from registered state only.
- Same register pending from both sources: busy stays set until the last write leaves the output stage.
- Pointers: log2(DEPTH)+1 bits each. Wrap-around is natural modulo; full and empty are distinguished by the MSB.

## Timing
- Reset (rst=1 at an edge) takes effect mid-operation:
  - all FIFOs flushed
  - w_en=0, rd_addr=0, w_data=0
  - last_grant=1
  - busy=0
  - s0_ready=s1_ready=1 in the following cycle
- Input accepted at edge E → earliest pop at edge E+1 → w_en=1 during cycle E+1..E+2 → regfile commits at edge E+2.
- busy bit rises in the cycle after edge E and falls in the cycle after edge E+2.
- Throughput: one write per cycle sustained. Two sources sharing one write port saturate at a combined 1 result/cycle; each source gets ≥1 of every 2 grants under contention.
- Empty FIFO pushed at edge E cannot be popped at edge E; there is no bypass.

## Test plan
- Reset: hold rst 2 cycles mid-traffic with both FIFOs full.
  - → w_en=0, busy=0, s0_ready=s1_ready=1 on the first cycle after release; no stale write ever appears.
- Single write: s0 pushes {rd=5, data=400} at edge E.
  - → w_en=1, rd_addr=5, w_data=400 in cycle E+1..E+2; busy[5]=1 for exactly 2 cycles.
  - → a regfile read of x5 returns 400 after edge E+2.
- x0 drop: s1 pushes {rd=0, data=0xDEAD}.
  - → w_en stays 0; busy stays 0.
  - → next tie goes to s0 (rotation advanced).
- Contention: both sources push every cycle for 6 cycles.
  - s0 data 10,11,…; s1 data 20,21,…; distinct rd.
  - → writes alternate s0,s1,s0,s1…, starting with s0 (10).
  - → each ready drops when its FIFO holds DEPTH=2 entries.
  - → no entry lost or duplicated.
- Full/wrap: s1 alone pushes 5 entries back-to-back while s0 is idle.
  - → s1_ready stays 1.
  - → writes appear in order, one per cycle; pointer wrap causes no reorder.
- Overlapping busy: s0 and s1 both target rd=7 on the same edge.
  - → busy[7] stays 1 until the second write leaves the output stage.
  - → the final regfile value is s1's data (s0 wins the tie first).

Source files
------------

// File: rtl/regfile_wb_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_if
// Brief   : Producer-side handshakes and regfile write port of the wb arbiter.
// Revision: 1.0
// ============================================================================
interface regfile_wb_if #(
    parameter int WIDTH = 32
);
    logic             s0_valid;
    logic             s0_ready;
    logic [4:0]       s0_rd_addr;
    logic [WIDTH-1:0] s0_data;
    logic             s1_valid;
    logic             s1_ready;
    logic [4:0]       s1_rd_addr;
    logic [WIDTH-1:0] s1_data;
    logic             w_en;
    logic [4:0]       rd_addr;
    logic [WIDTH-1:0] w_data;
    logic [31:0]      busy;

    modport master (
        output s0_valid, s0_rd_addr, s0_data,
        output s1_valid, s1_rd_addr, s1_data,
        input  s0_ready, s1_ready,
        input  w_en, rd_addr, w_data, busy
    );

    modport slave (
        input  s0_valid, s0_rd_addr, s0_data,
        input  s1_valid, s1_rd_addr, s1_data,
        output s0_ready, s1_ready,
        output w_en, rd_addr, w_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter
// Brief   : Buffers ALU/MEM results in per-source FIFOs and round-robins them
//           onto the single regfile write port; exports a pending-write mask.
// Revision: 1.0
// ============================================================================
module regfile_wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    regfile_wb_if.slave     bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int NSRC = 2;

    logic             w_in_valid  [NSRC];
    logic [4:0]       w_in_addr   [NSRC];
    logic [WIDTH-1:0] w_in_data   [NSRC];
    logic             w_full      [NSRC];
    logic             w_empty     [NSRC];
    logic             w_pop       [NSRC];
    logic [4:0]       w_head_addr [NSRC];
    logic [WIDTH-1:0] w_head_data [NSRC];
    logic [31:0]      w_fifo_busy [NSRC];

    assign w_in_valid[0] = bus.s0_valid;
    assign w_in_addr[0]  = bus.s0_rd_addr;
    assign w_in_data[0]  = bus.s0_data;
    assign w_in_valid[1] = bus.s1_valid;
    assign w_in_addr[1]  = bus.s1_rd_addr;
    assign w_in_data[1]  = bus.s1_data;

    assign bus.s0_ready = !w_full[0];
    assign bus.s1_ready = !w_full[1];

    generate
        for (genvar s = 0; s < NSRC; s++) begin : g_fifo
            logic [4:0]       r_addr_mem [DEPTH];
            logic [WIDTH-1:0] r_data_mem [DEPTH];
            logic [PW-1:0]    r_wr_ptr;
            logic [PW-1:0]    r_rd_ptr;
            logic [PW-1:0]    w_count;
            logic             w_push;
            logic [31:0]      w_mask;

            assign w_count    = r_wr_ptr - r_rd_ptr;
            assign w_empty[s] = (r_wr_ptr == r_rd_ptr);
            // Same slot index with differing lap bit means the FIFO is full.
            assign w_full[s]  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                                (r_wr_ptr[AW] != r_rd_ptr[AW]);
            assign w_push     = w_in_valid[s] && !w_full[s];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop[s]) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_addr_mem[r_wr_ptr[AW-1:0]] <= w_in_addr[s];
                    r_data_mem[r_wr_ptr[AW-1:0]] <= w_in_data[s];
                end
            end

            assign w_head_addr[s] = r_addr_mem[r_rd_ptr[AW-1:0]];
            assign w_head_data[s] = r_data_mem[r_rd_ptr[AW-1:0]];

            always_comb begin
                logic [PW-1:0] v_idx;
                w_mask = '0;
                v_idx  = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    v_idx = r_rd_ptr + PW'(i);
                    if (PW'(i) < w_count) begin
                        w_mask[r_addr_mem[v_idx[AW-1:0]]] = 1'b1;
                    end
                end
            end

            assign w_fifo_busy[s] = w_mask;
        end
    endgenerate

    logic             r_last_grant;
    logic             r_w_en;
    logic [4:0]       r_rd_addr;
    logic [WIDTH-1:0] r_w_data;
    logic             w_any;
    logic             w_sel;
    logic [4:0]       w_sel_addr;
    logic [WIDTH-1:0] w_sel_data;
    logic [31:0]      w_busy;

    // On a tie the source that did not win last time is served.
    always_comb begin
        w_any = !w_empty[0] || !w_empty[1];
        w_sel = 1'b0;
        if (!w_empty[0] && !w_empty[1]) begin
            w_sel = ~r_last_grant;
        end else if (!w_empty[1]) begin
            w_sel = 1'b1;
        end
        w_pop[0] = w_any && !w_sel;
        w_pop[1] = w_any && w_sel;
    end

    assign w_sel_addr = w_sel ? w_head_addr[1] : w_head_addr[0];
    assign w_sel_data = w_sel ? w_head_data[1] : w_head_data[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_w_en       <= 1'b0;
            r_rd_addr    <= '0;
            r_w_data     <= '0;
        end else begin
            r_w_en <= 1'b0;
            if (w_any) begin
                r_last_grant <= w_sel;
                // Writes to x0 are dropped but still advance the rotation.
                if (w_sel_addr != 5'd0) begin
                    r_w_en    <= 1'b1;
                    r_rd_addr <= w_sel_addr;
                    r_w_data  <= w_sel_data;
                end
            end
        end
    end

    always_comb begin
        w_busy = w_fifo_busy[0] | w_fifo_busy[1];
        if (r_w_en) begin
            w_busy[r_rd_addr] = 1'b1;
        end
        w_busy[0] = 1'b0;
    end

    assign bus.w_en    = r_w_en;
    assign bus.rd_addr = r_rd_addr;
    assign bus.w_data  = r_w_data;
    assign bus.busy    = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wb_arbiter
// Brief   : Directed and random traffic against a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_regfile_wb_arbiter;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_if #(.WIDTH(WIDTH)) bus ();

    regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one queue per source, pop-before-push each edge.
    typedef struct {
        logic [4:0]       a;
        logic [WIDTH-1:0] d;
    } ent_t;

    ent_t             mq0[$];
    ent_t             mq1[$];
    bit               m_last  = 1'b1;
    bit               m_wen   = 1'b0;
    logic [4:0]       m_addr  = '0;
    logic [WIDTH-1:0] m_data  = '0;
    bit               m_acc0  = 1'b0;
    bit               m_acc1  = 1'b0;
    bit               started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq0.delete();
            mq1.delete();
            m_last  = 1'b1;
            m_wen   = 1'b0;
            m_addr  = '0;
            m_data  = '0;
            m_acc0  = 1'b0;
            m_acc1  = 1'b0;
            started = 1'b1;
        end else begin
            bit   r0, r1, n0, n1, sel;
            ent_t e;
            r0 = mq0.size() < DEPTH;
            r1 = mq1.size() < DEPTH;
            n0 = mq0.size() != 0;
            n1 = mq1.size() != 0;
            m_wen = 1'b0;
            if (n0 || n1) begin
                sel = (n0 && n1) ? !m_last : n1;
                if (sel) e = mq1.pop_front();
                else     e = mq0.pop_front();
                m_last = sel;
                if (e.a != 5'd0) begin
                    m_wen  = 1'b1;
                    m_addr = e.a;
                    m_data = e.d;
                end
            end
            m_acc0 = (bus.s0_valid === 1'b1) && r0;
            m_acc1 = (bus.s1_valid === 1'b1) && r1;
            if (m_acc0) mq0.push_back('{bus.s0_rd_addr, bus.s0_data});
            if (m_acc1) mq1.push_back('{bus.s1_rd_addr, bus.s1_data});
        end
    end

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = '0;
        foreach (mq0[i]) b[mq0[i].a] = 1'b1;
        foreach (mq1[i]) b[mq1[i].a] = 1'b1;
        if (m_wen) b[m_addr] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    always @(posedge clk) begin
        #1;
        if (started) begin
            chk("w_en",     bus.w_en,     m_wen);
            chk("rd_addr",  bus.rd_addr,  m_addr);
            chk("w_data",   bus.w_data,   m_data);
            chk("busy",     bus.busy,     m_busy());
            chk("s0_ready", bus.s0_ready, mq0.size() < DEPTH);
            chk("s1_ready", bus.s1_ready, mq1.size() < DEPTH);
        end
    end

    // Stand-in regfile and write log fed by the DUT write port.
    logic [WIDTH-1:0] tb_rf [32];
    logic [WIDTH-1:0] wlog[$];

    always @(posedge clk) begin
        if (bus.w_en === 1'b1) begin
            tb_rf[bus.rd_addr] = bus.w_data;
            wlog.push_back(bus.w_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
    endtask

    task automatic drive0(input logic [4:0] a, input logic [WIDTH-1:0] d);
        bus.s0_valid   = 1'b1;
        bus.s0_rd_addr = a;
        bus.s0_data    = d;
    endtask

    task automatic drive1(input logic [4:0] a, input logic [WIDTH-1:0] d);
        bus.s1_valid   = 1'b1;
        bus.s1_rd_addr = a;
        bus.s1_data    = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, d1;
        idle();
        bus.s0_rd_addr = '0;
        bus.s0_data    = '0;
        bus.s1_rd_addr = '0;
        bus.s1_data    = '0;
        foreach (tb_rf[i]) tb_rf[i] = '0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        chk("reset w_en",     bus.w_en, 1'b0);
        chk("reset busy",     bus.busy, 32'h0);
        chk("reset s0_ready", bus.s0_ready, 1'b1);
        chk("reset s1_ready", bus.s1_ready, 1'b1);

        // Single write to x5.
        drive0(5'd5, 400);
        step();
        idle();
        chk("single busy5 E",  bus.busy[5], 1'b1);
        chk("single w_en E",   bus.w_en, 1'b0);
        step();
        chk("single w_en E1",  bus.w_en, 1'b1);
        chk("single rd_addr",  bus.rd_addr, 5'd5);
        chk("single w_data",   bus.w_data, 400);
        chk("single busy5 E1", bus.busy[5], 1'b1);
        step();
        chk("single busy5 E2", bus.busy[5], 1'b0);
        chk("single w_en E2",  bus.w_en, 1'b0);
        chk("regfile x5",      tb_rf[5], 400);

        // x0 drop, then a tie that must go to s0.
        drive1(5'd0, 32'hDEAD);
        step();
        idle();
        chk("x0 busy E", bus.busy, 32'h0);
        step();
        chk("x0 w_en",    bus.w_en, 1'b0);
        chk("x0 busy E1", bus.busy, 32'h0);
        drive0(5'd1, 32'h111);
        drive1(5'd2, 32'h222);
        step();
        idle();
        step();
        chk("tie first rd",  bus.rd_addr, 5'd1);
        chk("tie first dat", bus.w_data, 32'h111);
        step();
        chk("tie second rd",  bus.rd_addr, 5'd2);
        chk("tie second dat", bus.w_data, 32'h222);
        step();

        // Contention: both sources offer every cycle for 6 cycles.
        wlog.delete();
        d0 = 10;
        d1 = 20;
        for (int c = 0; c < 6; c++) begin
            drive0(5'(8 + d0 - 10), d0);
            drive1(5'(16 + d1 - 20), d1);
            step();
            if (m_acc0) d0++;
            if (m_acc1) d1++;
            if (c == 1) begin
                chk("cont s1 full",    bus.s1_ready, 1'b0);
                chk("cont s0 notfull", bus.s0_ready, 1'b1);
            end
        end
        idle();
        repeat (8) step();
        chk("cont count", wlog.size(), (d0 - 10) + (d1 - 20));
        if (wlog.size() >= 4) begin
            chk("cont order0", wlog[0], 10);
            chk("cont order1", wlog[1], 20);
            chk("cont order2", wlog[2], 11);
            chk("cont order3", wlog[3], 21);
        end

        // s1 alone, five back-to-back pushes across the pointer wrap.
        wlog.delete();
        for (int k = 0; k < 5; k++) begin
            chk("wrap s1_ready", bus.s1_ready, 1'b1);
            drive1(5'(20 + k), 32'h500 + k);
            step();
        end
        idle();
        repeat (4) step();
        chk("wrap count", wlog.size(), 5);
        if (wlog.size() == 5) begin
            for (int k = 0; k < 5; k++) chk("wrap order", wlog[k], 32'h500 + k);
        end

        // Both sources target x7 on the same edge.
        drive0(5'd7, 32'h70);
        drive1(5'd7, 32'h71);
        step();
        idle();
        chk("ovl busy7 E",  bus.busy[7], 1'b1);
        step();
        chk("ovl busy7 E1", bus.busy[7], 1'b1);
        step();
        chk("ovl busy7 E2", bus.busy[7], 1'b1);
        step();
        chk("ovl busy7 E3", bus.busy[7], 1'b0);
        chk("ovl regfile x7", tb_rf[7], 32'h71);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            bus.s0_valid   = ($urandom_range(0, 3) != 0);
            bus.s0_rd_addr = 5'($urandom_range(0, 31));
            bus.s0_data    = $urandom;
            bus.s1_valid   = ($urandom_range(0, 2) != 0);
            bus.s1_rd_addr = 5'($urandom_range(0, 31));
            bus.s1_data    = $urandom;
            step();
        end

        // Reset in the middle of saturated traffic.
        for (int c = 0; c < 5; c++) begin
            drive0(5'(3 + c), 32'hA0 + c);
            drive1(5'(12 + c), 32'hB0 + c);
            step();
        end
        idle();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        wlog.delete();
        chk("midrst w_en",     bus.w_en, 1'b0);
        chk("midrst busy",     bus.busy, 32'h0);
        chk("midrst s0_ready", bus.s0_ready, 1'b1);
        chk("midrst s1_ready", bus.s1_ready, 1'b1);
        repeat (5) step();
        chk("midrst no stale write", wlog.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
